// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// Memory-access and write-back stage of the 5-stage MIPS pipeline. Takes the
// EX/MEM slot, runs loads and stores against data memory over a req/ack
// handshake (stalling upstream while an access is outstanding), extracts and
// extends sub-word loads (big-endian lanes) and drives the register file
// write port back to decode.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   ex_valid                 EX/MEM slot holds a live instruction
//   alu_result               ALU result, or effective address for memory ops
//   store_data               rt value for stores
//   dest_reg                 destination register
//   m                        {size[1:0], mem_read, mem_write}
//                            size: 00 word, 01 byte signed, 10 half unsigned,
//                            11 byte unsigned
//   wb                       {reg_write, mem_to_reg}
//   mem_stall                hold PC/IF/ID/EX this cycle
//   dmem_req/we/addr/wdata/be  data memory request (held stable in ACCESS)
//   dmem_ack, dmem_rdata     request complete, read word valid this cycle
//   reg_write, write_register, write_data_reg  register file write port
//   misalign                 one-cycle address-error pulse
module mem_wb_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [4:0]        dest_reg,
  input  logic [3:0]        m,
  input  logic [1:0]        wb,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              reg_write,
  output logic [4:0]        write_register,
  output logic [31:0]       write_data_reg,
  output logic              misalign
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nx;

  logic              is_read_in;
  logic              is_mem_in;
  logic [1:0]        size_in;
  logic              aligned_in;
  logic              accept;
  logic [ADDR_W-1:0] addr_in;
  logic [3:0]        be_in;
  logic [31:0]       wdata_in;

  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              read_q;
  logic [4:0]        dest_q;
  logic              rw_q;

  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_data;

  // mem_to_reg is implied by the op itself: loads always write the loaded
  // value, everything else writes the ALU result.
  logic              unused_bits;
  assign unused_bits = wb[0];

  // Decode of the incoming slot; read wins when both mem bits are set.
  assign is_read_in = m[1];
  assign is_mem_in  = m[1] | m[0];
  assign size_in    = m[3:2];
  assign addr_in    = alu_result[ADDR_W-1:0];
  assign accept     = (state == IDLE) && ex_valid && is_mem_in && aligned_in;

  // Word ops need both low address bits clear, half ops only bit 0; bytes
  // are always aligned.
  always_comb begin
    aligned_in = 1'b1;
    case (size_in)
      2'b00:   aligned_in = (alu_result[1:0] == 2'b00);
      2'b10:   aligned_in = ~alu_result[0];
      default: aligned_in = 1'b1;
    endcase
  end

  // Request lanes. Loads read the full word; stores replicate the datum
  // across all lanes and let the byte enables pick the target.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = 32'd0;
    if (!is_read_in) begin
      case (size_in)
        2'b00: wdata_in = store_data;
        2'b10: begin
          be_in    = alu_result[1] ? 4'b0011 : 4'b1100;
          wdata_in = {2{store_data[15:0]}};
        end
        default: begin
          be_in    = 4'b1000 >> alu_result[1:0];
          wdata_in = {4{store_data[7:0]}};
        end
      endcase
    end
  end

  // Big-endian extraction of the loaded value: offset 0 is bits [31:24].
  always_comb begin
    lane_byte = dmem_rdata[31:24];
    case (off_q)
      2'd0: lane_byte = dmem_rdata[31:24];
      2'd1: lane_byte = dmem_rdata[23:16];
      2'd2: lane_byte = dmem_rdata[15:8];
      2'd3: lane_byte = dmem_rdata[7:0];
    endcase
    lane_half = off_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    load_data = dmem_rdata;
    case (size_q)
      2'b00: load_data = dmem_rdata;
      2'b01: load_data = {{24{lane_byte[7]}}, lane_byte};
      2'b10: load_data = {16'd0, lane_half};
      2'b11: load_data = {24'd0, lane_byte};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and stall. The stall is raised in the accept cycle and held
  // until the ack cycle, so upstream advances on the same edge as the ack.
  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx  = ACCESS;
          mem_stall = 1'b1;
        end
      end
      ACCESS: begin
        mem_stall = ~dmem_ack;
        if (dmem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers. reg_write and misalign default low every cycle so
  // they can only ever be single-cycle pulses. The request fields are only
  // loaded on accept, which keeps them stable for the whole access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= 32'd0;
      dmem_be        <= 4'd0;
      reg_write      <= 1'b0;
      write_register <= 5'd0;
      write_data_reg <= 32'd0;
      misalign       <= 1'b0;
      off_q          <= 2'd0;
      size_q         <= 2'd0;
      read_q         <= 1'b0;
      dest_q         <= 5'd0;
      rw_q           <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      misalign  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem_in) begin
              reg_write      <= wb[1] & (dest_reg != 5'd0);
              write_register <= dest_reg;
              write_data_reg <= alu_result;
            end else if (!aligned_in) begin
              misalign <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= ~is_read_in;
              dmem_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
              dmem_be    <= be_in;
              dmem_wdata <= wdata_in;
              off_q      <= alu_result[1:0];
              size_q     <= size_in;
              read_q     <= is_read_in;
              dest_q     <= dest_reg;
              rw_q       <= wb[1];
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (read_q) begin
              reg_write      <= rw_q & (dest_q != 5'd0);
              write_register <= dest_q;
              write_data_reg <= load_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Directed and randomized checks of mem_wb_stage against a behavioural model
// of the stage: each instruction's expected stall, request fields and
// write-back result are computed from the addressing rules with plain
// arithmetic.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic [3:0]  m;
  logic [1:0]  wb;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data_reg;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
    .store_data(store_data), .dest_reg(dest_reg), .m(m), .wb(wb),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .reg_write(reg_write),
    .write_register(write_register), .write_data_reg(write_data_reg),
    .misalign(misalign)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] alu,
                               input logic [31:0] sd, input logic [4:0] dest,
                               input logic [3:0] mm, input logic [1:0] wbv);
    ex_valid   = v;
    alu_result = alu;
    store_data = sd;
    dest_reg   = dest;
    m          = mm;
    wb         = wbv;
  endtask

  // Loaded value as the register file should see it; k is the byte offset,
  // byte 0 being the most significant.
  function automatic logic [31:0] modelLoad(input logic [1:0] size, input int k,
                                            input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * (3 - k))) & 32'h0000_00FF;
    h = (word >> (16 * (1 - k / 2))) & 32'h0000_FFFF;
    case (size)
      2'd0:    return word;
      2'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      2'd2:    return h;
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] modelBe(input bit isRead, input logic [1:0] size,
                                          input int k);
    if (isRead || size == 2'd0) return 32'd15;
    if (size == 2'd2)           return (k < 2) ? 32'd12 : 32'd3;
    return 32'd8 >> k;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] size,
                                             input logic [31:0] sd);
    if (size == 2'd0) return sd;
    if (size == 2'd2) return (sd & 32'h0000_FFFF) * 32'h0001_0001;
    return (sd & 32'h0000_00FF) * 32'h0101_0101;
  endfunction

  // Presents one instruction, plays the memory side with the given ack delay
  // and read word, and checks stall, request and write-back as it goes.
  task automatic doInstr(input string tag, input logic v, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] dest,
                         input logic [3:0] mm, input logic [1:0] wbv,
                         input int ackDelay, input logic [31:0] rdata);
    bit          isMem, isRead, aligned, expRw;
    int          k;
    logic [1:0]  size;
    logic [31:0] addr;
    isMem   = v && (mm[1] || mm[0]);
    isRead  = mm[1];
    size    = mm[3:2];
    k       = int'(alu[1:0]);
    aligned = (size == 2'd0) ? (k == 0) : (size == 2'd2) ? (k % 2 == 0) : 1'b1;
    dmem_ack = 1'b0;
    applyStimulus(v, alu, sd, dest, mm, wbv);
    #1;
    checkOutput({tag, ":stall_accept"}, 32'(mem_stall), 32'(isMem && aligned));
    @(posedge clk); #1;
    if (!(isMem && aligned)) begin
      expRw = v && !isMem && wbv[1] && (dest != 5'd0);
      checkOutput({tag, ":reg_write"}, 32'(reg_write), 32'(expRw));
      if (expRw) begin
        checkOutput({tag, ":write_register"}, 32'(write_register), 32'(dest));
        checkOutput({tag, ":write_data"}, write_data_reg, alu);
      end
      checkOutput({tag, ":misalign"}, 32'(misalign), 32'(isMem));
      checkOutput({tag, ":no_req"}, 32'(dmem_req), 32'd0);
    end else begin
      addr = alu - 32'(k);
      checkOutput({tag, ":req"}, 32'(dmem_req), 32'd1);
      checkOutput({tag, ":we"}, 32'(dmem_we), 32'(!isRead));
      checkOutput({tag, ":addr"}, dmem_addr, addr);
      checkOutput({tag, ":be"}, 32'(dmem_be), modelBe(isRead, size, k));
      if (!isRead) checkOutput({tag, ":wdata"}, dmem_wdata, modelWdata(size, sd));
      checkOutput({tag, ":rw_accept"}, 32'(reg_write), 32'd0);
      checkOutput({tag, ":misalign_accept"}, 32'(misalign), 32'd0);
      // A live ALU op sits on the inputs during the access; it must be ignored.
      applyStimulus(1'b1, $urandom, $urandom, 5'd7, 4'b0000, 2'b10);
      for (int i = 0; i < ackDelay; i++) begin
        #1;
        checkOutput({tag, ":stall_wait"}, 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, ":req_hold"}, 32'(dmem_req), 32'd1);
        checkOutput({tag, ":addr_hold"}, dmem_addr, addr);
        checkOutput({tag, ":rw_wait"}, 32'(reg_write), 32'd0);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      #1;
      checkOutput({tag, ":stall_ack"}, 32'(mem_stall), 32'd0);
      @(posedge clk); #1;
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      checkOutput({tag, ":req_drop"}, 32'(dmem_req), 32'd0);
      expRw = isRead && wbv[1] && (dest != 5'd0);
      checkOutput({tag, ":reg_write"}, 32'(reg_write), 32'(expRw));
      if (expRw) begin
        checkOutput({tag, ":write_register"}, 32'(write_register), 32'(dest));
        checkOutput({tag, ":write_data"}, write_data_reg, modelLoad(size, k, rdata));
      end
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 4'b0000, 2'b00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] alu;
    logic [3:0]  mm;
    logic [4:0]  dest;

    rst        = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 4'b0000, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset:req", 32'(dmem_req), 32'd0);
    checkOutput("reset:we", 32'(dmem_we), 32'd0);
    checkOutput("reset:addr", dmem_addr, 32'd0);
    checkOutput("reset:wdata", dmem_wdata, 32'd0);
    checkOutput("reset:be", 32'(dmem_be), 32'd0);
    checkOutput("reset:reg_write", 32'(reg_write), 32'd0);
    checkOutput("reset:write_register", 32'(write_register), 32'd0);
    checkOutput("reset:write_data", write_data_reg, 32'd0);
    checkOutput("reset:misalign", 32'(misalign), 32'd0);
    checkOutput("reset:stall", 32'(mem_stall), 32'd0);
    rst = 1'b1;

    doInstr("rtype", 1'b1, 32'h1234_5678, 32'd0, 5'd5, 4'b0000, 2'b10, 0, 32'd0);
    doInstr("lb", 1'b1, 32'h0000_0103, 32'd0, 5'd8, 4'b0110, 2'b10, 3, 32'h1122_3380);
    doInstr("lbu", 1'b1, 32'h0000_0103, 32'd0, 5'd9, 4'b1110, 2'b10, 3, 32'h1122_3380);
    doInstr("lhu", 1'b1, 32'h0000_0102, 32'd0, 5'd10, 4'b1010, 2'b10, 3, 32'h1122_3380);
    doInstr("sh", 1'b1, 32'h0000_0202, 32'h0000_BEEF, 5'd11, 4'b1001, 2'b00, 0, 32'd0);
    doInstr("lw_mis", 1'b1, 32'h0000_0301, 32'd0, 5'd12, 4'b0010, 2'b10, 0, 32'd0);
    @(posedge clk); #1;
    checkOutput("lw_mis:pulse_end", 32'(misalign), 32'd0);
    doInstr("lw_r0", 1'b1, 32'h0000_0304, 32'd0, 5'd0, 4'b0010, 2'b10, 1, 32'hCAFE_F00D);

    // Reset while the access waits, then a stray ack.
    applyStimulus(1'b1, 32'h0000_0500, 32'd0, 5'd13, 4'b0010, 2'b10);
    @(posedge clk); #1;
    checkOutput("rst_acc:req", 32'(dmem_req), 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 4'b0000, 2'b00);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_acc:req_drop", 32'(dmem_req), 32'd0);
    rst        = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    #1;
    checkOutput("rst_acc:stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checkOutput("rst_acc:stray_ack", 32'(reg_write), 32'd0);
    checkOutput("rst_acc:no_req", 32'(dmem_req), 32'd0);

    doInstr("b2b_sw", 1'b1, 32'h0000_0400, 32'hA5A5_0F0F, 5'd14, 4'b0001, 2'b10, 1, 32'd0);
    doInstr("b2b_lw", 1'b1, 32'h0000_0400, 32'd0, 5'd15, 4'b0010, 2'b10, 2, 32'hA5A5_0F0F);

    // Ack while idle must be ignored.
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checkOutput("idle_ack:reg_write", 32'(reg_write), 32'd0);

    for (int n = 0; n < 60; n++) begin
      alu  = $urandom;
      mm   = 4'($urandom);
      dest = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      doInstr("rand", ($urandom_range(0, 7) != 0), alu, $urandom, dest, mm,
              2'($urandom), $urandom_range(0, 3), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
